radix4_lane_merge: RTL and testbench
====================================

Name: radix4_lane_merge

Overview:
- Inverse of the serial-to-4-lane signal selector: collects four parallel 32-bit lanes carrying one 16-point frame over 4 beats and re-serializes them into one sample per clock.
- Sits at the FFT output, after the radix-4 butterfly stage, and feeds downstream serial consumers.
- Ping-pong 2x16-word buffer, so back-to-back frames stream without bubbles.
- Optional radix-4 digit-reversal on readout.

Parameters:
- WIDTH, 32, sample width in bits (signed).
- ORDER, 0, readout order: 0 = natural index, 1 = radix-4 digit-reversed.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous active-high reset.
- in_valid  input  1  lanes carry a valid beat this cycle.
- in_ready  output  1  block can accept a beat this cycle.
- in_0  input  WIDTH  lane 0 (frame index 0+k on beat k).
- in_1  input  WIDTH  lane 1 (index 4+k).
- in_2  input  WIDTH  lane 2 (index 8+k).
- in_3  input  WIDTH  lane 3 (index 12+k).
- out_data  output  WIDTH  serial sample, registered.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  high with the 16th sample of a frame.
- out_index  output  4  frame index of the sample on out_data.

Behaviour:
- Reset: asynchronous, active-high; clk and reset are the only clock/reset.
  - Clears all control state.
  - out_valid=0, out_last=0, out_data=0, out_index=0, in_ready=1.
  - Both banks marked EMPTY; buffer contents need not be cleared.
- Beat acceptance:
  - A beat is accepted when in_valid && in_ready.
  - Beat counter k (2 bits) selects the word slot; lane j is stored at index 4j+k of the write bank.
  - On k==3 the write bank is marked FULL, the write pointer toggles and k wraps to 0.
- Bank state per bank: EMPTY -> FILLING (first beat) -> FULL (4th beat) -> DRAINING (read starts) -> EMPTY (16th sample handshaken).
- in_ready = (write bank is EMPTY or FILLING); in_ready is low only when both banks are FULL/DRAINING.
- Read side:
  - Read counter p (4 bits) runs over the read bank.
  - ORDER=0: emitted index = p. ORDER=1: p = 4a+b emits index 4b+a.
  - out_index reflects the emitted index.
  - Output register advances when !out_valid || out_ready (standard valid/ready, data held stable while out_valid && !out_ready).
  - out_last = 1 when p==15.
  - After the last sample is handshaken, the read bank returns to EMPTY and the read pointer toggles.
- Latency:
  - Fill-to-first-output: 1 cycle; out_valid rises on the clock edge after the edge that captures beat 3, provided the output register is free.
  - Sustained throughput: 16 samples per 16 cycles. Input at 4 beats per 16 cycles never stalls while out_ready=1.
- Simultaneous events:
  - A write to one bank and a read-out of the other in the same cycle are independent.
  - Freeing the read bank and accepting the first beat into it in the same cycle is permitted: the beat is accepted only if in_ready was already 1 that cycle, i.e. no combinational ready path from out_ready to in_ready.
- in_valid low mid-frame: k holds; the partial frame waits indefinitely.
- Reset mid-frame or mid-drain: everything is discarded; the output restarts only after a new complete frame.
- Arithmetic: pure data movement, no sign changes, widths preserved.

Test Plan:
- Single frame, natural order: lane j on beat k = 4j+k, 4 consecutive beats, out_ready=1 -> out_data 0,1,...,15 on consecutive cycles; first out_valid one cycle after beat 3; out_last only on 15.
- ORDER=1, same stimulus -> out_data 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; out_index matches out_data.
- Back-to-back: frame A values 0..15, frame B values 100..115, input continuous at 1 beat per 4 cycles -> 32 contiguous output samples, in_ready never low.
- Backpressure: out_ready=0 for 20 cycles during drain of frame A while frames B and C are offered -> B is stored, in_ready drops after B completes, out_data holds stable, no loss; full order resumes when out_ready=1.
- Input gaps: in_valid toggled 1,0,0,1,1,0,1 for a frame -> same output as the gapless run.
- Reset asserted at beat 2 of frame A, then frame B (values 200..215) sent -> only 200..215 emitted; all outputs 0 during reset.

Source files
------------

// File: rtl/radix4_lane_merge.sv
// Collects a 16-point frame from four parallel lanes over four beats into a ping-pong
// buffer and re-serializes it, optionally in radix-4 digit-reversed order.
module radix4_lane_merge #(
  parameter int WIDTH = 32,
  parameter int ORDER = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [3:0]       out_index
);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  bank_state_t bank_q [2];
  bank_state_t bank_d [2];

  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       k_q, k_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [3:0]       p_q, p_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [3:0]       out_index_q, out_index_d;
  logic             out_bank_q, out_bank_d;

  logic             beat_acc;
  logic             rd_avail;
  logic             out_adv;
  logic             load;
  logic             out_free;
  logic [3:0]       rd_idx;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] lane_in [4];
  logic [WIDTH-1:0] lane_rd [4];

  assign lane_in[0] = in_0;
  assign lane_in[1] = in_1;
  assign lane_in[2] = in_2;
  assign lane_in[3] = in_3;

  // Ready depends only on registered bank state, never on out_ready.
  assign in_ready = (bank_q[wr_ptr_q] == BANK_EMPTY) || (bank_q[wr_ptr_q] == BANK_FILLING);
  assign beat_acc = in_valid && in_ready;

  assign rd_avail = (bank_q[rd_ptr_q] == BANK_FULL) || (bank_q[rd_ptr_q] == BANK_DRAINING);
  assign out_adv  = !out_valid_q || out_ready;
  assign load     = out_adv && rd_avail;
  assign out_free = out_valid_q && out_ready && out_last_q;

  // p = 4a+b reads index 4b+a when digit-reversed.
  assign rd_idx = (ORDER == 1) ? {p_q[1:0], p_q[3:2]} : p_q;

  // Each lane owns the four words 4j..4j+3 of both banks, addressed by {bank, k}.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [WIDTH-1:0] mem [8];

      always_ff @(posedge clk) begin
        if (beat_acc) begin
          mem[{wr_ptr_q, k_q}] <= lane_in[gi];
        end
      end

      assign lane_rd[gi] = mem[{rd_ptr_q, rd_idx[1:0]}];
    end
  endgenerate

  assign rd_word = lane_rd[rd_idx[3:2]];

  // The write bank, the bank being read and the bank being freed are never the same
  // bank when their events coincide, so the updates below do not conflict.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_d[b] = bank_q[b];
      if (beat_acc && (wr_ptr_q == 1'(b))) begin
        bank_d[b] = (k_q == 2'd3) ? BANK_FULL : BANK_FILLING;
      end
      if (load && (rd_ptr_q == 1'(b)) && (bank_q[b] == BANK_FULL)) begin
        bank_d[b] = BANK_DRAINING;
      end
      if (out_free && (out_bank_q == 1'(b))) begin
        bank_d[b] = BANK_EMPTY;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    k_d      = k_q;
    if (beat_acc) begin
      k_d = k_q + 2'd1;
      if (k_q == 2'd3) begin
        wr_ptr_d = ~wr_ptr_q;
      end
    end
  end

  // The read pointer moves on as soon as sample 15 is loaded; the bank itself is
  // released only once that sample has been taken downstream.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    p_d         = p_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_index_d = out_index_q;
    out_bank_d  = out_bank_q;
    if (load) begin
      p_d         = p_q + 4'd1;
      out_data_d  = rd_word;
      out_valid_d = 1'b1;
      out_last_d  = (p_q == 4'd15);
      out_index_d = rd_idx;
      out_bank_d  = rd_ptr_q;
      if (p_q == 4'd15) begin
        rd_ptr_d = ~rd_ptr_q;
      end
    end else if (out_adv) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        bank_q[b] <= BANK_EMPTY;
      end
      wr_ptr_q    <= 1'b0;
      k_q         <= 2'd0;
      rd_ptr_q    <= 1'b0;
      p_q         <= 4'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= 4'd0;
      out_bank_q  <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        bank_q[b] <= bank_d[b];
      end
      wr_ptr_q    <= wr_ptr_d;
      k_q         <= k_d;
      rd_ptr_q    <= rd_ptr_d;
      p_q         <= p_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
      out_bank_q  <= out_bank_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_index = out_index_q;

endmodule

// File: tb/tb_radix4_lane_merge.sv
// Directed bench for radix4_lane_merge: natural-order and digit-reversed instances share
// the same stimulus; a per-instance scoreboard queue holds the expected serial stream.
module tb_radix4_lane_merge;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [W-1:0] in_0 = '0, in_1 = '0, in_2 = '0, in_3 = '0;

  logic         in_ready_a, out_valid_a, out_last_a;
  logic [W-1:0] out_data_a;
  logic [3:0]   out_index_a;
  logic         in_ready_b, out_valid_b, out_last_b;
  logic [W-1:0] out_data_b;
  logic [3:0]   out_index_b;

  radix4_lane_merge #(.WIDTH(W), .ORDER(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_last(out_last_a), .out_index(out_index_a)
  );

  radix4_lane_merge #(.WIDTH(W), .ORDER(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_last(out_last_b), .out_index(out_index_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   idx;
    logic         last;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic         stall_a = 1'b0, stall_b = 1'b0;
  logic [W-1:0] hold_a = '0, hold_b = '0;
  logic         win_arm = 1'b0;
  int           hs_a = 0;
  int           gap_cnt = 0;
  int           in_stall_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] base);
    for (int i = 0; i < 16; i++) begin
      int r;
      r = (i % 4) * 4 + i / 4;
      q_a.push_back('{base + W'(i), 4'(i), (i == 15)});
      q_b.push_back('{base + W'(r), 4'(r), (i == 15)});
    end
  endtask

  // Holds a beat on the lanes until an edge at which in_ready was high.
  task automatic put_beat(input logic [W-1:0] base, input int k);
    logic acc;
    int t;
    acc = 1'b0;
    t = 0;
    in_valid = 1'b1;
    in_0 = base + W'(k);
    in_1 = base + W'(4 + k);
    in_2 = base + W'(8 + k);
    in_3 = base + W'(12 + k);
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      t++;
    end
    check($sformatf("beat_accept_b%0h_k%0d", base, k), acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(tag, q_a.size() + q_b.size(), 0);
    idle(2);
  endtask

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (stall_a) begin
        check("hold_valid_a", out_valid_a, 1);
        check("hold_data_a", out_data_a, hold_a);
      end
      if (stall_b) begin
        check("hold_valid_b", out_valid_b, 1);
        check("hold_data_b", out_data_b, hold_b);
      end
      if (win_arm && hs_a > 0 && hs_a < 32 && !out_valid_a) gap_cnt++;
      if (win_arm && in_valid && !in_ready_a) in_stall_cnt++;
      if (out_valid_a && out_ready) begin
        if (q_a.size() == 0) check("extra_out_a", q_a.size(), 1);
        else begin
          exp_t e;
          e = q_a.pop_front();
          $display("t=%0t nat  data=%0d idx=%0d last=%0b", $time, out_data_a, out_index_a, out_last_a);
          check("data_a", out_data_a, e.data);
          check("index_a", out_index_a, e.idx);
          check("last_a", out_last_a, e.last);
        end
        hs_a++;
      end
      if (out_valid_b && out_ready) begin
        if (q_b.size() == 0) check("extra_out_b", q_b.size(), 1);
        else begin
          exp_t e;
          e = q_b.pop_front();
          $display("t=%0t rev  data=%0d idx=%0d last=%0b", $time, out_data_b, out_index_b, out_last_b);
          check("data_b", out_data_b, e.data);
          check("index_b", out_index_b, e.idx);
          check("last_b", out_last_b, e.last);
        end
      end
      stall_a = out_valid_a && !out_ready;
      stall_b = out_valid_b && !out_ready;
      hold_a = out_data_a;
      hold_b = out_data_b;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid_a, 0);
    check("rst_last", out_last_a, 0);
    check("rst_data", out_data_a, 0);
    check("rst_index", out_index_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    check("rst_valid_b", out_valid_b, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Single frame, first output one cycle after beat 3
    push_frame(32'd0);
    for (int k = 0; k < 4; k++) put_beat(32'd0, k);
    check("lat_not_yet", out_valid_a, 0);
    @(posedge clk);
    #1;
    check("lat_valid", out_valid_a, 1);
    check("lat_first_data", out_data_a, 0);
    check("lat_first_data_b", out_data_b, 0);
    wait_drain("drain_single");
    check("idle_after_single", out_valid_a, 0);

    // Back-to-back frames at one beat per four cycles
    hs_a = 0;
    gap_cnt = 0;
    in_stall_cnt = 0;
    win_arm = 1'b1;
    push_frame(32'd0);
    push_frame(32'd100);
    for (int k = 0; k < 4; k++) begin
      put_beat(32'd0, k);
      idle(3);
    end
    for (int k = 0; k < 4; k++) begin
      put_beat(32'd100, k);
      idle(3);
    end
    wait_drain("drain_b2b");
    win_arm = 1'b0;
    check("b2b_count", hs_a, 32);
    check("b2b_gaps", gap_cnt, 0);
    check("b2b_in_stall", in_stall_cnt, 0);

    // Backpressure for 20 cycles while frames B and C are offered
    push_frame(32'd400);
    push_frame(32'd500);
    push_frame(32'd600);
    for (int k = 0; k < 4; k++) put_beat(32'd400, k);
    idle(4);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) put_beat(32'd500, k);
    check("bp_in_ready_low", in_ready_a, 0);
    in_valid = 1'b1;
    in_0 = 32'd600;
    in_1 = 32'd604;
    in_2 = 32'd608;
    in_3 = 32'd612;
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    check("bp_still_blocked", in_ready_a, 0);
    check("bp_held_valid", out_valid_a, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) put_beat(32'd600, k);
    wait_drain("drain_bp");

    // Input gaps 1,0,0,1,1,0,1
    push_frame(32'd700);
    put_beat(32'd700, 0);
    idle(2);
    put_beat(32'd700, 1);
    put_beat(32'd700, 2);
    idle(1);
    check("gap_partial_waits", out_valid_a, 0);
    put_beat(32'd700, 3);
    wait_drain("drain_gaps");

    // Reset during beat 2 of a frame
    put_beat(32'd800, 0);
    put_beat(32'd800, 1);
    in_valid = 1'b1;
    in_0 = 32'd802;
    in_1 = 32'd806;
    in_2 = 32'd810;
    in_3 = 32'd814;
    reset = 1'b1;
    #1;
    check("mid_rst_data", out_data_a, 0);
    check("mid_rst_index", out_index_a, 0);
    check("mid_rst_valid", out_valid_a, 0);
    check("mid_rst_last", out_last_a, 0);
    check("mid_rst_in_ready", in_ready_a, 1);
    q_a.delete();
    q_b.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(6);
    check("post_rst_quiet", out_valid_a, 0);
    push_frame(32'd200);
    for (int k = 0; k < 4; k++) put_beat(32'd200, k);
    wait_drain("drain_post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
